// File: rtl/vector_alu_sequencer.sv
// Sequences the vector element ALU against the vector register file.
// Optional repeat passes (A fed back from S) are enabled by VSEQ_REPEAT_EN.
module vector_alu_sequencer #(
    parameter int BITS  = 8,
    parameter int N     = 64,
    parameter int REGS  = 4,
    parameter int REG_W = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_scalar_sel,
    input  logic [BITS-1:0]  cmd_scalar,
    input  logic [REG_W-1:0] cmd_src_a,
    input  logic [REG_W-1:0] cmd_src_b,
    input  logic [REG_W-1:0] cmd_dst,
    input  logic [3:0]       cmd_rpt,
    output logic [REG_W-1:0] rf_rd_a_addr,
    output logic [REG_W-1:0] rf_rd_b_addr,
    output logic             a_fb_sel,
    output logic [2:0]       alu_op_sel,
    output logic             alu_scalar_sel,
    output logic [BITS-1:0]  alu_scalar,
    output logic             alu_set,
    output logic             alu_en,
    output logic             rf_wr_en,
    output logic [REG_W-1:0] rf_wr_addr,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        OPER,
        WB
    } state_t;

    state_t state;

    // N only sizes the datapath outside this block
    logic [31:0] unused_n;
    assign unused_n = 32'(N);

    assign cmd_ready = (state == IDLE);

`ifdef VSEQ_REPEAT_EN
    logic [3:0] rpt_q;
    logic [3:0] pass_cnt;
`else
    logic [3:0] unused_rpt;
    assign unused_rpt = cmd_rpt;
    assign a_fb_sel   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            rf_wr_en       <= 1'b0;
            rf_wr_addr     <= '0;
            alu_set        <= 1'b0;
            alu_en         <= 1'b0;
            alu_op_sel     <= '0;
            alu_scalar_sel <= 1'b0;
            alu_scalar     <= '0;
            rf_rd_a_addr   <= '0;
            rf_rd_b_addr   <= '0;
`ifdef VSEQ_REPEAT_EN
            a_fb_sel       <= 1'b0;
            rpt_q          <= '0;
            pass_cnt       <= '0;
`endif
        end else begin
            done     <= 1'b0;
            rf_wr_en <= 1'b0;
            alu_set  <= 1'b0;
            alu_en   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state          <= OPER;
                        busy           <= 1'b1;
                        alu_set        <= 1'b1;
                        alu_en         <= 1'b1;
                        alu_op_sel     <= cmd_op;
                        alu_scalar_sel <= cmd_scalar_sel;
                        alu_scalar     <= cmd_scalar;
                        rf_rd_a_addr   <= cmd_src_a;
                        rf_rd_b_addr   <= cmd_src_b;
                        rf_wr_addr     <= cmd_dst;
`ifdef VSEQ_REPEAT_EN
                        a_fb_sel       <= 1'b0;
                        rpt_q          <= cmd_rpt;
                        pass_cnt       <= '0;
`endif
                    end
                end
                OPER: begin
`ifdef VSEQ_REPEAT_EN
                    if (pass_cnt == rpt_q) begin
                        state    <= WB;
                        rf_wr_en <= 1'b1;
                        done     <= 1'b1;
                        a_fb_sel <= 1'b0;
                    end else begin
                        // later passes take A from the ALU result
                        pass_cnt <= pass_cnt + 4'd1;
                        alu_set  <= 1'b1;
                        alu_en   <= 1'b1;
                        a_fb_sel <= 1'b1;
                    end
`else
                    state    <= WB;
                    rf_wr_en <= 1'b1;
                    done     <= 1'b1;
`endif
                end
                WB: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Directed bench for vector_alu_sequencer with a behavioural
// register file and element ALU around the sequencer.
module tb_vector_alu_sequencer;

    localparam int BITS  = 8;
    localparam int N     = 64;
    localparam int REGS  = 4;
    localparam int REG_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic             cmd_scalar_sel;
    logic [BITS-1:0]  cmd_scalar;
    logic [REG_W-1:0] cmd_src_a;
    logic [REG_W-1:0] cmd_src_b;
    logic [REG_W-1:0] cmd_dst;
    logic [3:0]       cmd_rpt;
    logic [REG_W-1:0] rf_rd_a_addr;
    logic [REG_W-1:0] rf_rd_b_addr;
    logic             a_fb_sel;
    logic [2:0]       alu_op_sel;
    logic             alu_scalar_sel;
    logic [BITS-1:0]  alu_scalar;
    logic             alu_set;
    logic             alu_en;
    logic             rf_wr_en;
    logic [REG_W-1:0] rf_wr_addr;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    vector_alu_sequencer #(
        .BITS(BITS), .N(N), .REGS(REGS), .REG_W(REG_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_scalar_sel(cmd_scalar_sel),
        .cmd_scalar(cmd_scalar),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .cmd_dst(cmd_dst), .cmd_rpt(cmd_rpt),
        .rf_rd_a_addr(rf_rd_a_addr), .rf_rd_b_addr(rf_rd_b_addr),
        .a_fb_sel(a_fb_sel), .alu_op_sel(alu_op_sel),
        .alu_scalar_sel(alu_scalar_sel), .alu_scalar(alu_scalar),
        .alu_set(alu_set), .alu_en(alu_en),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
        .busy(busy), .done(done)
    );

    // environment: register file + ALU result register
    logic [7:0] rf_d [REGS][N];
    int         rf_len [REGS];
    logic [7:0] s_d [N];
    int         s_len;
    logic       ld_en = 1'b0;
    int         ld_addr, ld_base, ld_step, ld_len;
    int         set_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] fb_log = '0;
    int         wr_q [$];

    function automatic logic [7:0] alu_f(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return 8'(a * b);
            default: return a & b;
        endcase
    endfunction

    always @(posedge clk) begin
        if (ld_en) begin
            for (int i = 0; i < N; i++)
                rf_d[ld_addr][i] <= 8'(ld_base + ld_step * i);
            rf_len[ld_addr] <= ld_len;
        end
        if (rf_wr_en) begin
            for (int i = 0; i < N; i++)
                rf_d[rf_wr_addr][i] <= s_d[i];
            rf_len[rf_wr_addr] <= s_len;
            wr_q.push_back(int'(rf_wr_addr));
        end
        if (done) done_cnt <= done_cnt + 1;
        if (alu_set && alu_en) begin
            int al, bl;
            al = a_fb_sel ? s_len : rf_len[rf_rd_a_addr];
            bl = rf_len[rf_rd_b_addr];
            for (int i = 0; i < N; i++) begin
                logic [7:0] a, b;
                a = a_fb_sel ? s_d[i] : rf_d[rf_rd_a_addr][i];
                b = alu_scalar_sel ? alu_scalar
                                   : rf_d[rf_rd_b_addr][i];
                s_d[i] <= alu_f(alu_op_sel, a, b);
            end
            s_len   <= alu_scalar_sel ? al : ((al > bl) ? al : bl);
            set_cnt <= set_cnt + 1;
            fb_log  <= {fb_log[6:0], a_fb_sel};
        end
    end

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input int base, input int step,
                        input int len);
        ld_addr = a; ld_base = base; ld_step = step; ld_len = len;
        ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic ss,
                         input logic [7:0] sc, input logic [1:0] a,
                         input logic [1:0] b, input logic [1:0] d,
                         input logic [3:0] rpt);
        cmd_op = op; cmd_scalar_sel = ss; cmd_scalar = sc;
        cmd_src_a = a; cmd_src_b = b; cmd_dst = d; cmd_rpt = rpt;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    int k;
    int nwr;
    int ndone;
    int exp_k;
    int exp_pulses;
    logic [3:0] exp_fb;
    logic [7:0] exp_mul;

    initial begin
`ifdef VSEQ_REPEAT_EN
        exp_k = 4; exp_pulses = 4; exp_fb = 4'b0111; exp_mul = 8'd32;
`else
        exp_k = 1; exp_pulses = 1; exp_fb = 4'b0000; exp_mul = 8'd4;
`endif
        rst = 1'b1;
        issue(3'd0, 1'b0, 8'd0, 2'd0, 2'd0, 2'd0, 4'd0);
        cmd_valid = 1'b0;
        @(negedge clk);
        load(0, 1, 1, 40);
        load(1, 10, 0, 64);
        load(2, 0, 0, 64);
        load(3, 0, 0, 64);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_set", 32'({alu_set, alu_en, rf_wr_en, a_fb_sel}), 0);
        chk("rst_ctl", 32'({alu_op_sel, alu_scalar_sel, alu_scalar}), 0);
        chk("rst_addr", 32'({rf_rd_a_addr, rf_rd_b_addr, rf_wr_addr}), 0);
        rst = 1'b0;
        @(negedge clk);

        // add v0+v1 -> v2
        issue(3'b000, 1'b0, 8'd0, 2'd0, 2'd1, 2'd2, 4'd0);
        @(negedge clk);
        chk("add_busy", 32'({busy, cmd_ready}), 32'b10);
        chk("add_set", 32'({alu_set, alu_en, a_fb_sel}), 32'b110);
        chk("add_rd", 32'({rf_rd_a_addr, rf_rd_b_addr}), 32'b0001);
        cmd_valid = 1'b0;
        wait_done(k);
        chk("add_lat", 32'(k), 1);
        chk("add_wr", 32'({rf_wr_en, rf_wr_addr}), 32'b110);
        @(negedge clk);
        chk("add_idle", 32'({cmd_ready, busy, done}), 32'b100);
        chk("add_v0", 32'(rf_d[2][0]), 11);
        chk("add_v63", 32'(rf_d[2][63]), 74);
        chk("add_len", 32'(rf_len[2]), 64);

        // scalar sub v0-7 -> v0
        load(0, 5, 0, 40);
        issue(3'b001, 1'b1, 8'd7, 2'd0, 2'd3, 2'd0, 4'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(k);
        @(negedge clk);
        chk("sub_v0", 32'(rf_d[0][0]), 32'hFE);
        chk("sub_v50", 32'(rf_d[0][50]), 32'hFE);
        chk("sub_len", 32'(rf_len[0]), 40);

        // repeat multiply by scalar 2, rpt=3 -> v3
        load(0, 2, 0, 40);
        nwr = set_cnt;
        issue(3'b010, 1'b1, 8'd2, 2'd0, 2'd1, 2'd3, 4'd3);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(k);
        chk("mul_lat", 32'(k), 32'(exp_k));
        chk("mul_pulses", 32'(set_cnt - nwr), 32'(exp_pulses));
        chk("mul_fb", 32'(fb_log[3:0]), 32'(exp_fb));
        @(negedge clk);
        chk("mul_v0", 32'(rf_d[3][0]), 32'(exp_mul));
        chk("mul_len", 32'(rf_len[3]), 40);

        // backpressure: second command held during busy
        load(0, 1, 1, 40);
        nwr = wr_q.size();
        issue(3'b000, 1'b0, 8'd0, 2'd0, 2'd1, 2'd2, 4'd0);
        @(negedge clk);
        issue(3'b001, 1'b1, 8'd3, 2'd1, 2'd0, 2'd1, 4'd0);
        chk("bp_ready0", 32'(cmd_ready), 0);
        wait_done(k);
        chk("bp_op_hold", 32'(alu_op_sel), 0);
        @(negedge clk);
        chk("bp_idle", 32'({cmd_ready, busy}), 32'b10);
        @(negedge clk);
        chk("bp_acc2", 32'({busy, alu_op_sel}), 32'b1001);
        cmd_valid = 1'b0;
        wait_done(k);
        repeat (5) @(negedge clk);
        chk("bp_nwr", 32'(wr_q.size() - nwr), 2);
        if (wr_q.size() >= nwr + 2) begin
            chk("bp_wr1", 32'(wr_q[nwr]), 2);
            chk("bp_wr2", 32'(wr_q[nwr + 1]), 1);
        end
        chk("bp_v2", 32'(rf_d[2][5]), 16);
        chk("bp_v1", 32'(rf_d[1][0]), 7);

        // reset one cycle into OPER
        nwr   = wr_q.size();
        ndone = done_cnt;
        issue(3'b000, 1'b0, 8'd0, 2'd0, 2'd1, 2'd3, 4'd2);
        @(negedge clk);
        chk("rs_busy", 32'(busy), 1);
        rst = 1'b1;
        cmd_valid = 1'b0;
        #1;
        chk("rs_ready", 32'({cmd_ready, busy, done}), 32'b100);
        chk("rs_set", 32'({alu_set, alu_en, rf_wr_en, a_fb_sel}), 0);
        chk("rs_ctl", 32'({alu_op_sel, alu_scalar_sel, alu_scalar}), 0);
        chk("rs_addr", 32'({rf_rd_a_addr, rf_rd_b_addr, rf_wr_addr}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rs_nwr", 32'(wr_q.size() - nwr), 0);
        chk("rs_ndone", 32'(done_cnt - ndone), 0);
        chk("rs_v3", 32'(rf_d[3][0]), 32'(exp_mul));
        chk("rs_idle", 32'({cmd_ready, busy}), 32'b10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vector_alu_sequencer.md
# vector_alu_sequencer

Command-driven controller that sequences the vector element ALU against the vector register file. It accepts one vector instruction at a time over a valid/ready handshake and drives register-file read addresses, ALU operation/scalar controls and the ALU result-register strobes. It then writes the result vector and length back to a destination register. Optionally it iterates an operation on its own result (repeat passes) before writeback.

## Interface
Parameters:
- BITS, 8, element and scalar width; matches the ALU.
- N, 64, elements per vector; matches the ALU and register file.
- REGS, 4, number of vector registers in the register file.
- REG_W, $clog2(REGS), register address width.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  ALU op_sel encoding: 000 add, 001 sub, 010 mul, 011 cmp, 1xx logic.
- cmd_scalar_sel  in  1  B operand is the scalar, not a register.
- cmd_scalar  in  BITS  scalar operand.
- cmd_src_a, cmd_src_b, cmd_dst  in  REG_W each  source and destination registers.
- cmd_rpt  in  4  extra passes; total passes = cmd_rpt+1.
- rf_rd_a_addr, rf_rd_b_addr  out  REG_W  register-file read addresses; the register file reads combinationally, data and length included.
- a_fb_sel  out  1  external A-operand mux: 1 selects the ALU result S/S_len, 0 selects register-file port A.
- alu_op_sel  out  3, alu_scalar_sel  out  1, alu_scalar  out  BITS  ALU controls.
- alu_set, alu_en  out  1 each  the ALU result register loads on an edge where both are high.
- rf_wr_en  out  1, rf_wr_addr  out  REG_W  writeback; the data is the ALU S/S_len.
- busy  out  1  command in flight.
- done  out  1  one-cycle pulse at writeback.

## Operation
- States are IDLE, OPER and WB.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch all cmd_* fields, clear pass_cnt, and go to OPER.
- OPER: rd addrs = latched src_a/src_b; alu_* = latched fields; alu_set=alu_en=1 for one cycle; a_fb_sel=(pass_cnt!=0).
  - If pass_cnt==rpt, go to WB.
  - Otherwise pass_cnt++ and stay in OPER. The next pass uses A=S and B unchanged.
- WB: rf_wr_en=1, rf_wr_addr=dst, done=1 for one cycle, then go to IDLE.
- busy=1 in OPER and WB. cmd_ready=0 outside IDLE. cmd_valid is ignored while busy; the command stays pending and is not dropped.
- All control outputs are registered state decodes except cmd_ready; no output glitches on cmd_* changes.
- pass_cnt is 4 bits and cannot wrap, because rpt≤15.
- dst equal to a source register is legal. The write in WB precedes any following command's read.

## Timing
- Reset values:
  - state=IDLE.
  - cmd_ready=1, busy=0, done=0, rf_wr_en=0, alu_set=0, alu_en=0, a_fb_sel=0.
  - alu_op_sel=0, alu_scalar_sel=0, alu_scalar=0, and all address outputs=0.
- rst asserted mid-command returns to IDLE immediately. There is no writeback and no done, and the latched command is discarded.
- Accept at edge E0. Passes occupy cycles E0..E0+rpt; the ALU captures at E1..E1+rpt.
- WB occupies the cycle after the last capture. The write commits at edge E2+rpt.
- The next command can be accepted at E3+rpt. Throughput is one command per rpt+3 cycles.
- done is high exactly during the WB cycle and coincides with rf_wr_en.

## Configuration
- VSEQ_REPEAT_EN defined: cmd_rpt is honoured, pass_cnt exists, and a_fb_sel asserts on passes ≥1.
- VSEQ_REPEAT_EN undefined: cmd_rpt is ignored and there is exactly one pass. a_fb_sel is tied 0 and pass_cnt is removed. Latency is fixed at 3 cycles per command.

## Test plan
- Add: v0=[1,2,...], v1=[10,10,...], op=000, dst=v2, rpt=0.
  - Expect v2=[11,12,...] and S_len=max(len0,len1).
  - done high 2 cycles after accept; ready high again in the next cycle.
- Scalar sub: v0=[5,...], scalar=7, scalar_sel=1, dst=v0.
  - Expect v0=[0xFE,...] and length=len0.
- Repeat multiply (macro on): v0=[2,...], scalar=2, op=010, rpt=3.
  - Expect 4 alu_set/alu_en pulses, a_fb_sel 0 then 1,1,1, and result [32,...].
- Macro off, same command: one pass only; result [4,...].
- Backpressure: hold cmd_valid with a second command during busy.
  - The second command is accepted only in IDLE after done.
  - Exactly two writebacks, in order.
- Reset: assert rst one cycle into OPER.
  - All outputs return to their reset values at once.
  - No rf_wr_en and no done; v-dst is unchanged.
